// File: rtl/operand_vector_loader_if.sv
// rtl/operand_vector_loader_if.sv - element-pair input and packed-vector output handshake bundle
interface operand_vector_loader_if #(
  parameter int DIM          = 10,
  parameter int A_DATA_WIDTH = 16,
  parameter int B_DATA_WIDTH = 16
);
  localparam int CW = $clog2(DIM + 1);

  logic                        InValid;
  logic                        InReady;
  logic [A_DATA_WIDTH-1:0]     InA;
  logic [B_DATA_WIDTH-1:0]     InB;
  logic                        OutValid;
  logic                        OutReady;
  logic [A_DATA_WIDTH*DIM-1:0] A;
  logic [B_DATA_WIDTH*DIM-1:0] B;
  logic [CW-1:0]               FillCount;

  modport master (
    output InValid, InA, InB, OutReady,
    input  InReady, OutValid, A, B, FillCount
  );

  modport slave (
    input  InValid, InA, InB, OutReady,
    output InReady, OutValid, A, B, FillCount
  );
endinterface

// File: rtl/operand_vector_loader.sv
// rtl/operand_vector_loader.sv - double-buffered serial-to-parallel operand packer feeding dotProduct
module operand_vector_loader #(
  parameter int DIM          = 10,
  parameter int A_DATA_WIDTH = 16,
  parameter int B_DATA_WIDTH = 16
) (
  input logic               Clock,
  input logic               Reset,
  operand_vector_loader_if.slave io
);
  localparam int CW = $clog2(DIM + 1);
  localparam int AV = A_DATA_WIDTH * DIM;
  localparam int BV = B_DATA_WIDTH * DIM;
  localparam logic [CW-1:0] LAST    = CW'(DIM - 1);
  localparam logic [CW-1:0] FULLCNT = CW'(DIM);

  logic [CW-1:0] cnt;
  logic          fill_full;
  logic [AV-1:0] fill_a, fill_a_nxt, out_a;
  logic [BV-1:0] fill_b, fill_b_nxt, out_b;
  logic          out_valid;
  logic          in_fire, out_free, out_fire;

  assign io.InReady  = !fill_full && !Reset;
  assign in_fire     = io.InValid && io.InReady;
  assign out_free    = !out_valid || io.OutReady;
  assign out_fire    = out_valid && io.OutReady;

  assign io.OutValid  = out_valid;
  assign io.A         = out_a;
  assign io.B         = out_b;
  assign io.FillCount = fill_full ? FULLCNT : cnt;

  // Fill register with the incoming pair dropped into lane cnt
  always_comb begin
    fill_a_nxt = fill_a;
    fill_b_nxt = fill_b;
    fill_a_nxt[int'(cnt)*A_DATA_WIDTH +: A_DATA_WIDTH] = io.InA;
    fill_b_nxt[int'(cnt)*B_DATA_WIDTH +: B_DATA_WIDTH] = io.InB;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt       <= '0;
      fill_full <= 1'b0;
      fill_a    <= '0;
      fill_b    <= '0;
      out_a     <= '0;
      out_b     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (out_fire) out_valid <= 1'b0;

      // A parked full vector has priority; no input is accepted while it waits
      if (fill_full) begin
        if (out_free) begin
          out_a     <= fill_a;
          out_b     <= fill_b;
          out_valid <= 1'b1;
          fill_full <= 1'b0;
          cnt       <= '0;
        end
      end else if (in_fire) begin
        if (cnt != LAST) begin
          fill_a <= fill_a_nxt;
          fill_b <= fill_b_nxt;
          cnt    <= cnt + CW'(1);
        end else if (out_free) begin
          out_a     <= fill_a_nxt;
          out_b     <= fill_b_nxt;
          out_valid <= 1'b1;
          cnt       <= '0;
        end else begin
          fill_a    <= fill_a_nxt;
          fill_b    <= fill_b_nxt;
          fill_full <= 1'b1;
        end
      end
    end
  end
endmodule
